// File: rtl/regfile_mp_sb.sv
// Two-write-port integer register file with a pending-load scoreboard and an I/O mailbox register.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data and load completion to the read ports.
module regfile_mp_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int IO_REG     = 31,
    parameter int OUT_REG    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] ra1,
    input  logic [ADDR_WIDTH-1:0] ra2,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2,
    output logic                  rd1_busy,
    output logic                  rd2_busy,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] wa_a,
    input  logic [DATA_WIDTH-1:0] wd_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] wa_b,
    input  logic [DATA_WIDTH-1:0] wd_b,
    input  logic                  iss_en,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic                  io_we,
    input  logic [DATA_WIDTH-1:0] io_in,
    output logic [DATA_WIDTH-1:0] io_out,
    output logic [DATA_WIDTH-1:0] a0,
    output logic                  pend_any
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] IO_IDX  = ADDR_WIDTH'(IO_REG);
    localparam logic [ADDR_WIDTH-1:0] OUT_IDX = ADDR_WIDTH'(OUT_REG);
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = {ADDR_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      pending;
    logic [ADDR_WIDTH-1:0] raddr [2];
    logic [DATA_WIDTH-1:0] rdata [2];
    logic                  rbusy [2];

    assign raddr[0] = ra1;
    assign raddr[1] = ra2;

    // Register array update: port A beats port B beats the mailbox; x0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (we_a && (wa_a == ADDR_WIDTH'(i))) begin
                    regs[i] <= wd_a;
                end else if (we_b && (wa_b == ADDR_WIDTH'(i))) begin
                    regs[i] <= wd_b;
                end else if (io_we && (IO_IDX == ADDR_WIDTH'(i))) begin
                    regs[i] <= io_in;
                end else begin
                    regs[i] <= regs[i];
                end
            end
        end
    end

    // Scoreboard: a newly issued load outranks the completion of an older one to the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= {DEPTH{1'b0}};
        end else begin
            pending[0] <= 1'b0;
            for (int i = 1; i < DEPTH; i++) begin
                if (iss_en && (iss_rd == ADDR_WIDTH'(i))) begin
                    pending[i] <= 1'b1;
                end else if (we_b && (wa_b == ADDR_WIDTH'(i))) begin
                    pending[i] <= 1'b0;
                end else begin
                    pending[i] <= pending[i];
                end
            end
        end
    end

    // Read ports: x0 and reset force zero data and no hazard.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = regs[raddr[p]];
            rbusy[p] = pending[raddr[p]];
`ifdef REGFILE_BYPASS_EN
            if (we_a && (wa_a == raddr[p])) begin
                rdata[p] = wd_a;
            end else if (we_b && (wa_b == raddr[p])) begin
                rdata[p] = wd_b;
            end else if (io_we && (raddr[p] == IO_IDX)) begin
                rdata[p] = io_in;
            end else begin
                rdata[p] = regs[raddr[p]];
            end
            if (we_b && (wa_b == raddr[p])) begin
                rbusy[p] = 1'b0;
            end else begin
                rbusy[p] = pending[raddr[p]];
            end
`endif
            if (rst || (raddr[p] == ZERO_IDX)) begin
                rdata[p] = {DATA_WIDTH{1'b0}};
                rbusy[p] = 1'b0;
            end else begin
                rdata[p] = rdata[p];
                rbusy[p] = rbusy[p];
            end
        end
    end

    assign rd1      = rdata[0];
    assign rd2      = rdata[1];
    assign rd1_busy = rbusy[0];
    assign rd2_busy = rbusy[1];
    assign io_out   = regs[IO_IDX];
    assign a0       = regs[OUT_IDX];
    assign pend_any = (|pending) & ~rst;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed, table-driven bench for regfile_mp_sb, plus hand sequences for bypass and reset corner cases.
module tb_regfile_mp_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra1, ra2, wa_a, wa_b, iss_rd;
    logic [31:0] rd1, rd2, wd_a, wd_b, io_in, io_out, a0;
    logic        rd1_busy, rd2_busy, we_a, we_b, iss_en, io_we, pend_any;

    int checks = 0;
    int failures = 0;

    regfile_mp_sb dut (
        .clk(clk), .rst(rst),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .rd1_busy(rd1_busy), .rd2_busy(rd2_busy),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
        .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
        .iss_en(iss_en), .iss_rd(iss_rd),
        .io_we(io_we), .io_in(io_in), .io_out(io_out),
        .a0(a0), .pend_any(pend_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we_a; logic [4:0] wa_a; logic [31:0] wd_a;
        logic        we_b; logic [4:0] wa_b; logic [31:0] wd_b;
        logic        iss_en; logic [4:0] iss_rd;
        logic        io_we; logic [31:0] io_in;
        logic [4:0]  ra1, ra2;
        logic [31:0] e_rd1, e_rd2;
        logic        e_b1, e_b2;
        logic [31:0] e_a0, e_io;
        logic        e_pend;
    } vec_t;

    function automatic vec_t mk(
        input logic ia, input logic [4:0] aa, input logic [31:0] da,
        input logic ib, input logic [4:0] ab, input logic [31:0] db,
        input logic ie, input logic [4:0] ir,
        input logic iw, input logic [31:0] ii,
        input logic [4:0] r1, input logic [4:0] r2,
        input logic [31:0] x1, input logic [31:0] x2,
        input logic b1, input logic b2,
        input logic [31:0] xa0, input logic [31:0] xio, input logic xp);
        vec_t v;
        v.we_a = ia; v.wa_a = aa; v.wd_a = da;
        v.we_b = ib; v.wa_b = ab; v.wd_b = db;
        v.iss_en = ie; v.iss_rd = ir; v.io_we = iw; v.io_in = ii;
        v.ra1 = r1; v.ra2 = r2; v.e_rd1 = x1; v.e_rd2 = x2;
        v.e_b1 = b1; v.e_b2 = b2; v.e_a0 = xa0; v.e_io = xio; v.e_pend = xp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        we_a = 1'b0; wa_a = 5'd0; wd_a = 32'd0;
        we_b = 1'b0; wa_b = 5'd0; wd_b = 32'd0;
        iss_en = 1'b0; iss_rd = 5'd0; io_we = 1'b0; io_in = 32'd0;
    endtask

    vec_t tbl [15];

    initial begin
        // State after each row accumulates from the rows above it.
        tbl[0]  = mk(0,0,0,            0,0,0,        0,0,  0,0,     0,0,   0,0,0,0, 0,0,0);
        tbl[1]  = mk(1,10,32'hDEADBEEF,0,0,0,        0,0,  0,0,     10,0,  32'hDEADBEEF,0,0,0, 32'hDEADBEEF,0,0);
        tbl[2]  = mk(1,0,32'h1234,     0,0,0,        0,0,  0,0,     0,10,  0,32'hDEADBEEF,0,0, 32'hDEADBEEF,0,0);
        tbl[3]  = mk(0,0,0,            0,0,0,        1,7,  0,0,     7,0,   0,0,1,0, 32'hDEADBEEF,0,1);
        tbl[4]  = mk(1,7,32'hAAAA,     1,7,32'h5555, 0,0,  0,0,     7,7,   32'hAAAA,32'hAAAA,0,0, 32'hDEADBEEF,0,0);
        tbl[5]  = mk(1,31,32'h99,      0,0,0,        0,0,  1,32'h1, 31,7,  32'h99,32'hAAAA,0,0, 32'hDEADBEEF,32'h99,0);
        tbl[6]  = mk(0,0,0,            0,0,0,        0,0,  1,32'h2, 31,7,  32'h2,32'hAAAA,0,0, 32'hDEADBEEF,32'h2,0);
        tbl[7]  = mk(0,0,0,            0,0,0,        1,3,  0,0,     31,3,  32'h2,0,0,1, 32'hDEADBEEF,32'h2,1);
        tbl[8]  = mk(0,0,0,            1,3,32'h11,   1,3,  0,0,     31,3,  32'h2,32'h11,0,1, 32'hDEADBEEF,32'h2,1);
        tbl[9]  = mk(0,0,0,            1,3,32'h77,   0,0,  0,0,     31,3,  32'h2,32'h77,0,0, 32'hDEADBEEF,32'h2,0);
        tbl[10] = mk(0,0,0,            0,0,0,        1,0,  0,0,     0,0,   0,0,0,0, 32'hDEADBEEF,32'h2,0);
        tbl[11] = mk(0,0,0,            1,31,32'h55,  0,0,  1,32'h66,31,3,  32'h55,32'h77,0,0, 32'hDEADBEEF,32'h55,0);
        tbl[12] = mk(1,10,32'h42,      0,0,0,        1,10, 0,0,     10,3,  32'h42,32'h77,1,0, 32'h42,32'h55,1);
        tbl[13] = mk(0,0,0,            1,10,32'h43,  0,0,  0,0,     10,3,  32'h43,32'h77,0,0, 32'h43,32'h55,0);
        tbl[14] = mk(0,0,0,            1,0,32'hFF,   0,0,  0,0,     0,10,  0,32'h43,0,0, 32'h43,32'h55,0);

        rst = 1'b1; idle(); ra1 = 5'd0; ra2 = 5'd0;
        #1;
        chk("reset_pend_any", {31'd0, pend_any}, 32'd0);
        chk("reset_a0", a0, 32'd0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            we_a = tbl[i].we_a; wa_a = tbl[i].wa_a; wd_a = tbl[i].wd_a;
            we_b = tbl[i].we_b; wa_b = tbl[i].wa_b; wd_b = tbl[i].wd_b;
            iss_en = tbl[i].iss_en; iss_rd = tbl[i].iss_rd;
            io_we = tbl[i].io_we; io_in = tbl[i].io_in;
            @(posedge clk);
            @(negedge clk);
            idle(); ra1 = tbl[i].ra1; ra2 = tbl[i].ra2;
            #1;
            chk($sformatf("v%0d_rd1", i), rd1, tbl[i].e_rd1);
            chk($sformatf("v%0d_rd2", i), rd2, tbl[i].e_rd2);
            chk($sformatf("v%0d_busy1", i), {31'd0, rd1_busy}, {31'd0, tbl[i].e_b1});
            chk($sformatf("v%0d_busy2", i), {31'd0, rd2_busy}, {31'd0, tbl[i].e_b2});
            chk($sformatf("v%0d_a0", i), a0, tbl[i].e_a0);
            chk($sformatf("v%0d_io_out", i), io_out, tbl[i].e_io);
            chk($sformatf("v%0d_pend_any", i), {31'd0, pend_any}, {31'd0, tbl[i].e_pend});
        end

        // Load to x4 completes while a reader looks at x4 in the same cycle.
        iss_en = 1'b1; iss_rd = 5'd4;
        @(posedge clk); @(negedge clk);
        idle(); we_b = 1'b1; wa_b = 5'd4; wd_b = 32'hCAFE; ra1 = 5'd4;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_same_rd1", rd1, 32'hCAFE);
        chk("byp_same_busy1", {31'd0, rd1_busy}, 32'd0);
`else
        chk("byp_same_rd1", rd1, 32'd0);
        chk("byp_same_busy1", {31'd0, rd1_busy}, 32'd1);
`endif
        @(posedge clk); @(negedge clk);
        idle();
        #1;
        chk("byp_next_rd1", rd1, 32'hCAFE);
        chk("byp_next_busy1", {31'd0, rd1_busy}, 32'd0);
        chk("byp_next_pend_any", {31'd0, pend_any}, 32'd0);

        // Same-cycle A and B writes to the read address.
        we_a = 1'b1; wa_a = 5'd4; wd_a = 32'h1;
        we_b = 1'b1; wa_b = 5'd4; wd_b = 32'h2;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_prio_rd1", rd1, 32'h1);
`else
        chk("byp_prio_rd1", rd1, 32'hCAFE);
`endif
        @(posedge clk); @(negedge clk);
        idle();
        #1;
        chk("prio_next_rd1", rd1, 32'h1);

        // Reset in the middle of an outstanding load to x5.
        we_a = 1'b1; wa_a = 5'd5; wd_a = 32'h5;
        @(posedge clk); @(negedge clk);
        idle(); iss_en = 1'b1; iss_rd = 5'd5;
        @(posedge clk); @(negedge clk);
        idle(); ra1 = 5'd5;
        #1;
        chk("pre_rst_busy1", {31'd0, rd1_busy}, 32'd1);
        chk("pre_rst_rd1", rd1, 32'h5);
        #2 rst = 1'b1;
        #1;
        chk("rst_rd1", rd1, 32'd0);
        chk("rst_busy1", {31'd0, rd1_busy}, 32'd0);
        chk("rst_pend_any", {31'd0, pend_any}, 32'd0);
        chk("rst_a0", a0, 32'd0);
        chk("rst_io_out", io_out, 32'd0);
        @(negedge clk);
        rst = 1'b0; we_b = 1'b1; wa_b = 5'd5; wd_b = 32'h9;
        @(posedge clk); @(negedge clk);
        idle();
        #1;
        chk("post_rst_rd1", rd1, 32'h9);
        chk("post_rst_busy1", {31'd0, rd1_busy}, 32'd0);
        chk("post_rst_pend_any", {31'd0, pend_any}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
